// File: rtl/q100_tcm_arb.sv
module q100_tcm_arb #(
  parameter int    DATA_WIDTH   = 32,
  parameter int    ADDR_WIDTH   = 12,
  parameter int    OUT_REG      = 0,
  parameter int    STARVE_LIMIT = 4,
  parameter string INIT_FILE    = ""
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    if_req_i,
  input  logic [ADDR_WIDTH-1:0]   if_addr_i,
  output logic                    if_gnt_o,
  output logic                    if_rvalid_o,
  output logic [DATA_WIDTH-1:0]   if_rdata_o,
  input  logic                    ls_req_i,
  input  logic                    ls_we_i,
  input  logic [DATA_WIDTH/8-1:0] ls_be_i,
  input  logic [ADDR_WIDTH-1:0]   ls_addr_i,
  input  logic [DATA_WIDTH-1:0]   ls_wdata_i,
  output logic                    ls_gnt_o,
  output logic                    ls_rvalid_o,
  output logic [DATA_WIDTH-1:0]   ls_rdata_o
);
  localparam int          BYTES = DATA_WIDTH / 8;
  localparam int          OFF   = $clog2(BYTES);
  localparam int          IDX_W = ADDR_WIDTH - OFF;
  localparam int unsigned DEPTH = 2 ** IDX_W;
  localparam int          SW    = (STARVE_LIMIT > 0) ? $clog2(STARVE_LIMIT + 1) : 1;

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  initial mem = '{default: '0};

  logic [SW-1:0]         starve_cnt;
  logic                  force_if;
  logic [IDX_W-1:0]      idx;
  logic                  rd_en;
  logic [DATA_WIDTH-1:0] wmask;
  logic [DATA_WIDTH-1:0] rd_data;

  assign force_if = (STARVE_LIMIT != 0) && (starve_cnt == SW'(STARVE_LIMIT));

  always_comb begin
    if_gnt_o = rst & if_req_i & (~ls_req_i | force_if);
    ls_gnt_o = rst & ls_req_i & ~(if_req_i & force_if);
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      starve_cnt <= '0;
    end else if (if_gnt_o || !if_req_i) begin
      starve_cnt <= '0;
    end else if (ls_gnt_o && starve_cnt != SW'(STARVE_LIMIT)) begin
      starve_cnt <= starve_cnt + 1'b1;
    end
  end

  assign idx   = if_gnt_o ? if_addr_i[ADDR_WIDTH-1:OFF] : ls_addr_i[ADDR_WIDTH-1:OFF];
  assign rd_en = if_gnt_o | (ls_gnt_o & ~ls_we_i);

  for (genvar k = 0; k < BYTES; k++) begin : g_wmask
    assign wmask[k*8 +: 8] = {8{ls_be_i[k]}};
  end

  if (OFF > 0) begin : g_unused_low
    logic unused_addr_low;
    assign unused_addr_low = ^{if_addr_i[OFF-1:0], ls_addr_i[OFF-1:0]};
  end

  always_ff @(posedge clk) begin
    if (ls_gnt_o && ls_we_i) begin
      mem[idx] <= (mem[idx] & ~wmask) | (ls_wdata_i & wmask);
    end
  end

  always_ff @(posedge clk) begin
    if (rd_en) begin
      rd_data <= mem[idx];
    end
  end

  logic s1_vld, s1_ls, s1_rd;
  always_ff @(posedge clk) begin
    if (!rst) begin
      s1_vld <= 1'b0;
      s1_ls  <= 1'b0;
      s1_rd  <= 1'b0;
    end else begin
      s1_vld <= if_gnt_o | ls_gnt_o;
      s1_ls  <= ls_gnt_o;
      s1_rd  <= rd_en;
    end
  end

  logic                  fin_vld, fin_ls, fin_rd;
  logic [DATA_WIDTH-1:0] fin_data;

  if (OUT_REG != 0) begin : g_out_reg
    logic                  s2_vld, s2_ls, s2_rd;
    logic [DATA_WIDTH-1:0] s2_data;
    always_ff @(posedge clk) begin
      if (!rst) begin
        s2_vld <= 1'b0;
        s2_ls  <= 1'b0;
        s2_rd  <= 1'b0;
      end else begin
        s2_vld <= s1_vld;
        s2_ls  <= s1_ls;
        s2_rd  <= s1_rd;
      end
    end
    always_ff @(posedge clk) begin
      if (s1_vld && s1_rd) begin
        s2_data <= rd_data;
      end
    end
    assign fin_vld  = s2_vld;
    assign fin_ls   = s2_ls;
    assign fin_rd   = s2_rd;
    assign fin_data = s2_data;
  end else begin : g_no_out_reg
    assign fin_vld  = s1_vld;
    assign fin_ls   = s1_ls;
    assign fin_rd   = s1_rd;
    assign fin_data = rd_data;
  end

  logic [DATA_WIDTH-1:0] if_hold, ls_hold;
  always_ff @(posedge clk) begin
    if (!rst) begin
      if_hold <= '0;
      ls_hold <= '0;
    end else begin
      if (if_rvalid_o) begin
        if_hold <= fin_data;
      end
      if (ls_rvalid_o && fin_rd) begin
        ls_hold <= fin_data;
      end
    end
  end

  assign if_rvalid_o = fin_vld & ~fin_ls;
  assign ls_rvalid_o = fin_vld & fin_ls;
  assign if_rdata_o  = if_rvalid_o ? fin_data : if_hold;
  assign ls_rdata_o  = (ls_rvalid_o && fin_rd) ? fin_data : ls_hold;

endmodule
